// File: rtl/branch_resolve_queue.sv
// In-order queue of branch predictions between fetch and execute; flushes on mispredict.
// Optional resolve/mispredict performance counters are built when BRQ_PERF_EN is defined.
module branch_resolve_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_f,
  input  logic [DATA_WIDTH-1:0] push_pc_f,
  input  logic                  push_taken_f,
  input  logic [DATA_WIDTH-1:0] push_target_f,
  input  logic                  push_jal_f,
  input  logic                  resolve_e,
  input  logic                  actual_taken_e,
  input  logic [DATA_WIDTH-1:0] actual_target_e,
  output logic                  full,
  output logic                  empty,
  output logic                  mispredict,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] branch_pc,
  output logic                  branch_actual_taken,
  output logic [DATA_WIDTH-1:0] branch_actual_target,
  output logic                  type_j,
  output logic                  overflow_err,
  output logic                  underflow_err,
  output logic [31:0]           resolved_count,
  output logic [31:0]           mispredict_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_C   = PW'(1);

  logic [DATA_WIDTH-1:0] pc_mem     [DEPTH];
  logic [DATA_WIDTH-1:0] target_mem [DEPTH];
  logic                  taken_mem  [DEPTH];
  logic                  jal_mem    [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, count_q, count_d;
  logic          overflow_q, overflow_d, underflow_q, underflow_d;
  logic          mispredict_q;
  logic [DATA_WIDTH-1:0] redirect_q, bpc_q, btarget_q, redirect_d;
  logic          btaken_q, type_j_q;

  logic [DATA_WIDTH-1:0] head_pc, head_target;
  logic          head_taken, head_jal;
  logic          valid_resolve, mispred, pop, push_ok;

  assign head_pc     = pc_mem[rd_ptr_q[AW-1:0]];
  assign head_target = target_mem[rd_ptr_q[AW-1:0]];
  assign head_taken  = taken_mem[rd_ptr_q[AW-1:0]];
  assign head_jal    = jal_mem[rd_ptr_q[AW-1:0]];

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Target only matters when both prediction and outcome are taken.
  assign valid_resolve = resolve_e && !empty;
  assign mispred = valid_resolve &&
                   ((head_taken != actual_taken_e) ||
                    (head_taken && actual_taken_e && (head_target != actual_target_e)));
  assign pop     = valid_resolve && !mispred;
  assign push_ok = push_f && !mispred && (!full || pop);
  assign redirect_d = actual_taken_e ? actual_target_e : head_pc + DATA_WIDTH'(4);

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (push_f && full && !pop && !mispred);
    underflow_d = underflow_q | (resolve_e && empty);
    if (mispred) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)
        rd_ptr_d = rd_ptr_q + ONE_C;
      if (push_ok)
        wr_ptr_d = wr_ptr_q + ONE_C;
      count_d = count_q + (push_ok ? ONE_C : '0) - (pop ? ONE_C : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wr_ptr_q[AW-1:0]]     <= push_pc_f;
      target_mem[wr_ptr_q[AW-1:0]] <= push_target_f;
      taken_mem[wr_ptr_q[AW-1:0]]  <= push_taken_f;
      jal_mem[wr_ptr_q[AW-1:0]]    <= push_jal_f;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      bpc_q        <= '0;
      btarget_q    <= '0;
      btaken_q     <= 1'b0;
      type_j_q     <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      mispredict_q <= mispred;
      // Update fields hold between valid resolves.
      if (valid_resolve) begin
        redirect_q <= redirect_d;
        bpc_q      <= head_pc;
        btarget_q  <= actual_target_e;
        btaken_q   <= actual_taken_e;
        type_j_q   <= head_jal;
      end
    end
  end

  assign mispredict           = mispredict_q;
  assign redirect_pc          = redirect_q;
  assign branch_pc            = bpc_q;
  assign branch_actual_taken  = btaken_q;
  assign branch_actual_target = btarget_q;
  assign type_j               = type_j_q;
  assign overflow_err         = overflow_q;
  assign underflow_err        = underflow_q;

`ifdef BRQ_PERF_EN
  logic [31:0] resolved_count_q, mispredict_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resolved_count_q   <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (valid_resolve)
        resolved_count_q <= resolved_count_q + 32'd1;
      if (mispred)
        mispredict_count_q <= mispredict_count_q + 32'd1;
    end
  end

  assign resolved_count   = resolved_count_q;
  assign mispredict_count = mispredict_count_q;
`else
  assign resolved_count   = '0;
  assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed vector table plus randomized run against a queue-based reference model.
module tb_branch_resolve_queue;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NVEC  = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_f, push_taken_f, push_jal_f, resolve_e, actual_taken_e;
  logic [DW-1:0] push_pc_f, push_target_f, actual_target_e;
  logic          full, empty, mispredict, branch_actual_taken, type_j;
  logic          overflow_err, underflow_err;
  logic [DW-1:0] redirect_pc, branch_pc, branch_actual_target;
  logic [31:0]   resolved_count, mispredict_count;

  branch_resolve_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .push_f(push_f), .push_pc_f(push_pc_f), .push_taken_f(push_taken_f),
    .push_target_f(push_target_f), .push_jal_f(push_jal_f),
    .resolve_e(resolve_e), .actual_taken_e(actual_taken_e), .actual_target_e(actual_target_e),
    .full(full), .empty(empty), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_pc(branch_pc), .branch_actual_taken(branch_actual_taken),
    .branch_actual_target(branch_actual_target), .type_j(type_j),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .resolved_count(resolved_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic push; logic [31:0] pc; logic ptaken; logic [31:0] ptgt; logic jal;
    logic res;  logic ataken; logic [31:0] atgt;
    logic e_misp; logic [31:0] e_red; logic [31:0] e_bpc;
    logic e_empty; logic e_full; logic e_ovf; logic e_unf;
  } vec_t;

  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic push, input logic [31:0] pc, input logic pt,
                              input logic [31:0] ptgt, input logic res, input logic at,
                              input logic [31:0] atgt, input logic misp, input logic [31:0] red,
                              input logic [31:0] bpc, input logic emp, input logic ful,
                              input logic ovf, input logic unf);
    vec_t v;
    v.push = push; v.pc = pc; v.ptaken = pt; v.ptgt = ptgt; v.jal = 1'b0;
    v.res = res; v.ataken = at; v.atgt = atgt;
    v.e_misp = misp; v.e_red = red; v.e_bpc = bpc;
    v.e_empty = emp; v.e_full = ful; v.e_ovf = ovf; v.e_unf = unf;
    return v;
  endfunction

  // Reference model: an ordinary queue of predictions plus last-update fields.
  typedef struct { logic [31:0] pc; logic t; logic [31:0] tgt; logic jal; } ent_t;
  ent_t        mq[$];
  logic        m_ovf, m_unf, m_misp, m_bat, m_tj;
  logic [31:0] m_red, m_bpc, m_batg;
  int unsigned m_rc, m_mc;

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_unf = 0; m_misp = 0; m_bat = 0; m_tj = 0;
    m_red = 0; m_bpc = 0; m_batg = 0; m_rc = 0; m_mc = 0;
  endtask

  task automatic model_step();
    bit   was_full;
    bit   mp;
    ent_t h;
    ent_t n;
    was_full = (mq.size() == DEPTH);
    mp = 0;
    if (resolve_e && mq.size() == 0) m_unf = 1;
    if (resolve_e && mq.size() > 0) begin
      h  = mq[0];
      mp = (h.t != actual_taken_e) || (h.t && actual_taken_e && h.tgt != actual_target_e);
      m_bpc = h.pc; m_bat = actual_taken_e; m_batg = actual_target_e; m_tj = h.jal;
      m_red = actual_taken_e ? actual_target_e : h.pc + 32'd4;
      m_rc++;
      if (mp) m_mc++;
    end
    m_misp = mp;
    if (mp) mq.delete();
    else begin
      if (resolve_e && mq.size() > 0) void'(mq.pop_front());
      if (push_f) begin
        if (!was_full || resolve_e) begin
          n.pc = push_pc_f; n.t = push_taken_f; n.tgt = push_target_f; n.jal = push_jal_f;
          mq.push_back(n);
        end else m_ovf = 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, " mispredict"}, mispredict, m_misp);
    chk({tag, " redirect_pc"}, redirect_pc, m_red);
    chk({tag, " branch_pc"}, branch_pc, m_bpc);
    chk({tag, " branch_actual_taken"}, branch_actual_taken, m_bat);
    chk({tag, " branch_actual_target"}, branch_actual_target, m_batg);
    chk({tag, " type_j"}, type_j, m_tj);
    chk({tag, " empty"}, empty, mq.size() == 0);
    chk({tag, " full"}, full, mq.size() == DEPTH);
    chk({tag, " overflow_err"}, overflow_err, m_ovf);
    chk({tag, " underflow_err"}, underflow_err, m_unf);
`ifdef BRQ_PERF_EN
    chk({tag, " resolved_count"}, resolved_count, m_rc);
    chk({tag, " mispredict_count"}, mispredict_count, m_mc);
`else
    chk({tag, " resolved_count"}, resolved_count, 0);
    chk({tag, " mispredict_count"}, mispredict_count, 0);
`endif
  endtask

  task automatic clear_inputs();
    push_f = 0; push_pc_f = 0; push_taken_f = 0; push_target_f = 0; push_jal_f = 0;
    resolve_e = 0; actual_taken_e = 0; actual_target_e = 0;
  endtask

  initial begin
    //            push pc           pt ptgt     res at atgt    misp red          bpc          emp ful ovf unf
    vecs[0]  = mk(1, 32'h100,       1, 32'h180,  0, 0, 0,       0, 0,           0,           0, 0, 0, 0);
    vecs[1]  = mk(0, 0,             0, 0,        1, 1, 32'h180, 0, 32'h180,     32'h100,     1, 0, 0, 0);
    vecs[2]  = mk(1, 32'h200,       0, 0,        0, 0, 0,       0, 32'h180,     32'h100,     0, 0, 0, 0);
    vecs[3]  = mk(0, 0,             0, 0,        1, 1, 32'h240, 1, 32'h240,     32'h200,     1, 0, 0, 0);
    vecs[4]  = mk(0, 0,             0, 0,        0, 0, 0,       0, 32'h240,     32'h200,     1, 0, 0, 0);
    vecs[5]  = mk(1, 32'h300,       1, 32'h340,  0, 0, 0,       0, 32'h240,     32'h200,     0, 0, 0, 0);
    vecs[6]  = mk(0, 0,             0, 0,        1, 0, 0,       1, 32'h304,     32'h300,     1, 0, 0, 0);
    vecs[7]  = mk(1, 32'hFFFFFFFC,  1, 32'h1000, 0, 0, 0,       0, 32'h304,     32'h300,     0, 0, 0, 0);
    vecs[8]  = mk(0, 0,             0, 0,        1, 0, 0,       1, 0,           32'hFFFFFFFC, 1, 0, 0, 0);
    vecs[9]  = mk(1, 32'h400,       0, 0,        0, 0, 0,       0, 0,           32'hFFFFFFFC, 0, 0, 0, 0);
    vecs[10] = mk(1, 32'h404,       0, 0,        0, 0, 0,       0, 0,           32'hFFFFFFFC, 0, 0, 0, 0);
    vecs[11] = mk(1, 32'h408,       0, 0,        0, 0, 0,       0, 0,           32'hFFFFFFFC, 0, 0, 0, 0);
    vecs[12] = mk(1, 32'h600,       0, 0,        1, 1, 32'h500, 1, 32'h500,     32'h400,     1, 0, 0, 0);
    vecs[13] = mk(0, 0,             0, 0,        0, 0, 0,       0, 32'h500,     32'h400,     1, 0, 0, 0);
    vecs[14] = mk(0, 0,             0, 0,        1, 0, 0,       0, 32'h500,     32'h400,     1, 0, 0, 1);
    vecs[15] = mk(1, 32'h700,       0, 0,        0, 0, 0,       0, 32'h500,     32'h400,     0, 0, 0, 1);
    vecs[16] = mk(1, 32'h704,       0, 0,        0, 0, 0,       0, 32'h500,     32'h400,     0, 0, 0, 1);
    vecs[17] = mk(1, 32'h708,       0, 0,        0, 0, 0,       0, 32'h500,     32'h400,     0, 0, 0, 1);
    vecs[18] = mk(1, 32'h70C,       0, 0,        0, 0, 0,       0, 32'h500,     32'h400,     0, 1, 0, 1);
    vecs[19] = mk(1, 32'h710,       0, 0,        0, 0, 0,       0, 32'h500,     32'h400,     0, 1, 1, 1);
    vecs[20] = mk(1, 32'h714,       0, 0,        1, 0, 0,       0, 32'h704,     32'h700,     0, 1, 1, 1);
    vecs[21] = mk(0, 0,             0, 0,        1, 1, 32'h900, 1, 32'h900,     32'h704,     1, 0, 1, 1);

    clear_inputs();
    rst = 1;
    model_reset();
    #2;
    compare_all("reset");
    @(posedge clk);
    #1 rst = 0;

    for (int i = 0; i < NVEC; i++) begin
      push_f = vecs[i].push; push_pc_f = vecs[i].pc; push_taken_f = vecs[i].ptaken;
      push_target_f = vecs[i].ptgt; push_jal_f = vecs[i].jal;
      resolve_e = vecs[i].res; actual_taken_e = vecs[i].ataken; actual_target_e = vecs[i].atgt;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d mispredict", i), mispredict, vecs[i].e_misp);
      chk($sformatf("vec%0d redirect_pc", i), redirect_pc, vecs[i].e_red);
      chk($sformatf("vec%0d branch_pc", i), branch_pc, vecs[i].e_bpc);
      chk($sformatf("vec%0d empty", i), empty, vecs[i].e_empty);
      chk($sformatf("vec%0d full", i), full, vecs[i].e_full);
      chk($sformatf("vec%0d overflow_err", i), overflow_err, vecs[i].e_ovf);
      chk($sformatf("vec%0d underflow_err", i), underflow_err, vecs[i].e_unf);
    end
`ifdef BRQ_PERF_EN
    chk("table resolved_count", resolved_count, 7);
    chk("table mispredict_count", mispredict_count, 5);
`endif

    // Asynchronous reset between clock edges, with live inputs.
    push_f = 1; push_pc_f = 32'h800; resolve_e = 1; actual_taken_e = 1; actual_target_e = 32'h880;
    #2 rst = 1;
    #1;
    model_reset();
    compare_all("async_reset");
    clear_inputs();
    @(posedge clk);
    #1 rst = 0;

    for (int c = 0; c < 500; c++) begin
      push_f        = ($urandom_range(0, 99) < 60);
      push_jal_f    = ($urandom_range(0, 3) == 0);
      push_taken_f  = push_jal_f ? 1'b1 : 1'($urandom_range(0, 1));
      push_pc_f     = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC);
      push_target_f = {24'h0, 6'($urandom_range(0, 3)), 2'b00};
      resolve_e     = ($urandom_range(0, 99) < 40);
      if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
        actual_taken_e  = mq[0].t;
        actual_target_e = mq[0].tgt;
      end else begin
        actual_taken_e  = 1'($urandom_range(0, 1));
        actual_target_e = {24'h0, 6'($urandom_range(0, 3)), 2'b00};
      end
      model_step();
      @(posedge clk);
      #1;
      compare_all($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order queue of branch predictions between fetch and execute. Fetch pushes one entry for every conditional branch or JAL it issues, holding the PC, predicted direction and predicted target. Execute pops the oldest entry when that instruction resolves and compares the actual outcome with the prediction. On a mismatch the block emits a one-cycle registered mispredict pulse with the correct redirect PC and the BTB update fields, and discards all younger (wrong-path) entries.

## Interface
- DATA_WIDTH, 32, PC/target width
- DEPTH, 4, queue entries; power of two, ≥2
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- push_f  in  1  fetch issues a conditional branch or JAL this cycle
- push_pc_f  in  DATA_WIDTH  PC of the pushed instruction
- push_taken_f  in  1  predicted taken
- push_target_f  in  DATA_WIDTH  predicted target (don't-care if not taken)
- push_jal_f  in  1  instruction is JAL
- resolve_e  in  1  execute resolves the oldest queued branch
- actual_taken_e  in  1  actual direction (JAL: 1)
- actual_target_e  in  DATA_WIDTH  actual taken target
- full  out  1  count == DEPTH (combinational from state)
- empty  out  1  count == 0
- mispredict  out  1  registered one-cycle pulse
- redirect_pc  out  DATA_WIDTH  correct next PC, valid with mispredict
- branch_pc  out  DATA_WIDTH  PC of the resolved entry
- branch_actual_taken  out  1  resolved direction
- branch_actual_target  out  DATA_WIDTH  resolved target
- type_j  out  1  resolved entry was JAL
- overflow_err  out  1  sticky: push dropped while full
- underflow_err  out  1  sticky: resolve while empty
- resolved_count  out  32  resolves seen (see Configuration)
- mispredict_count  out  32  mispredicts seen (see Configuration)

## Operation
- Storage: circular buffer of DEPTH entries {pc, taken, target, jal}; read pointer, write pointer and count are log2(DEPTH)+1 bits wide; pointers wrap modulo DEPTH.
- Push accepted when push_f and (count < DEPTH, or a non-mispredicting resolve occurs in the same cycle).
- Push when full with no pop: entry dropped; overflow_err set.
- Resolve when empty: ignored (no pop, no pulse); underflow_err set.
- Resolve when non-empty: the head entry is compared with the actual outcome.
  - Mispredict = (pred taken ≠ actual taken), or (both taken and pred target ≠ actual target).
  - redirect_pc = actual_taken_e ? actual_target_e : head.pc + 4, truncated to DATA_WIDTH (wraps).
- Mispredicting resolve: queue cleared (both pointers and count = 0); a push in the same cycle is dropped without setting overflow_err, since it is wrong-path.
- Correct resolve: head popped; a simultaneous push is accepted.
- Update outputs (branch_pc, branch_actual_taken, branch_actual_target, type_j, redirect_pc) are registered on every valid resolve. They hold their value until the next valid resolve.
- Error flags clear only on rst.

## Timing
- Resolve in cycle N: mispredict high in cycle N+1 only. The update fields carry entry N's data from N+1 onward.
- The flush takes effect at the N→N+1 edge, so empty = 1 in cycle N+1.
- full and empty reflect registered state only; they never depend on the same-cycle push or resolve.
- A push in cycle N is resolvable from cycle N+1.
- Reset (asynchronous, any cycle, including mid-flush): pointers and count = 0; empty = 1, full = 0; mispredict = 0; all data outputs = 0; error flags = 0; counters = 0. Entry storage need not be reset.

## Configuration
- BRQ_PERF_EN defined:
  - resolved_count increments on each valid resolve.
  - mispredict_count increments on each mispredict.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- BRQ_PERF_EN undefined: both counters are tied to 0 and no counter flops exist.

## Test plan
- Push {pc=0x100, taken=1, target=0x180}; resolve next cycle with taken=1, target=0x180 → mispredict stays 0, branch_pc=0x100, empty=1.
- Push {pc=0x200, taken=0}; resolve taken=1, target=0x240 → mispredict pulse for exactly 1 cycle, redirect_pc=0x240, branch_actual_taken=1, type_j=0.
- Push {pc=0x300, taken=1, target=0x340}; resolve taken=0 → redirect_pc=0x304. Wrap check: pc=0xFFFFFFFC, taken=1 predicted, resolve taken=0 → redirect_pc=0x0.
- Push 4 entries (DEPTH=4) → full=1. A 5th push alone → overflow_err=1, count stays 4. Push plus correct resolve in the same cycle → accepted, full stays 1.
- Queue holds 3 entries; head resolves mispredicted with a push in the same cycle → next cycle empty=1, the push is lost, overflow_err stays 0.
- Resolve while empty → underflow_err=1, no mispredict pulse. Assert rst mid-sequence → all outputs 0 with no clock edge; with BRQ_PERF_EN, after 3 resolves including 1 mispredict → resolved_count=3, mispredict_count=1.
